// File: rtl/rgmii_xmit_if.sv
// Payload stream, per-frame header fields and MII transmit side of rgmii_xmit.
interface rgmii_xmit_if;
  logic [47:0] dst_mac;
  logic [15:0] ethertype;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [3:0]  mii_txd;
  logic        mii_txctl;
  logic        busy;
  logic        frame_done;
  logic        tx_err;

  modport master (
    output dst_mac, ethertype, s_tdata, s_tvalid, s_tlast,
    input  s_tready, mii_txd, mii_txctl, busy, frame_done, tx_err
  );

  modport slave (
    input  dst_mac, ethertype, s_tdata, s_tvalid, s_tlast,
    output s_tready, mii_txd, mii_txctl, busy, frame_done, tx_err
  );
endinterface

// File: rtl/rgmii_xmit.sv
// Ethernet II nibble transmitter: preamble/SFD, DA, SA, type, payload, [pad with RGMII_XMIT_PAD_EN], FCS, IFG.
// Latency: first preamble nibble one cycle after the start request; payload byte accepted in N is on the wire at N+1/N+2.
// Backpressure: s_tready pulses once per byte on its last nibble slot; a missing byte there aborts the frame.
module rgmii_xmit #(
  parameter logic [47:0] MAC_ADDR    = 48'h0,
  parameter int          IFG_BYTES   = 12,
  parameter int          MIN_PAYLOAD = 46
) (
  input logic         clk,
  input logic         rst,
  rgmii_xmit_if.slave bus
);
  localparam int          IFG_CYC   = 2 * IFG_BYTES;
  localparam int          IFG_W     = $clog2(IFG_CYC + 1);
  localparam logic [10:0] MAX_BYTES = 11'd1500;
  localparam logic [10:0] SAT_BYTES = 11'd1501;

  if (MIN_PAYLOAD < 1 || MIN_PAYLOAD > 1500) begin : g_bad_min_payload
    $error("rgmii_xmit: MIN_PAYLOAD must be within 1..1500");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DEST, S_SOURCE, S_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t           state;
  logic [3:0]       nib_cnt;
  logic [10:0]      byte_cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic [47:0]      sh;
  logic [15:0]      type_q;
  logic [3:0]       hi_nib;
  logic             last_q;
  logic [31:0]      crc;
  logic [3:0]       txd_q;
  logic             txctl_q;
  logic             tready_q;
  logic             done_q;
  logic             err_q;

  // Reflected CRC-32 (0xEDB88320), one nibble LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c_in, input logic [3:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // crc holds every covered nibble already sent; crc_next folds in the one on the wire now.
  logic [31:0] crc_next;
  logic [31:0] fcs;
  assign crc_next = crc_nib(crc, txd_q);
  assign fcs      = ~crc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      nib_cnt  <= '0;
      byte_cnt <= '0;
      ifg_cnt  <= '0;
      sh       <= '0;
      type_q   <= '0;
      hi_nib   <= '0;
      last_q   <= 1'b0;
      crc      <= 32'hFFFFFFFF;
      txd_q    <= '0;
      txctl_q  <= 1'b0;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tready_q <= 1'b0;
      if (tready_q) begin
        // Byte slot: last TYPE nibble or high nibble of a non-last byte.
        crc <= crc_next;
        if (bus.s_tvalid) begin
          state    <= S_PAYLOAD;
          nib_cnt  <= '0;
          txd_q    <= bus.s_tdata[3:0];
          hi_nib   <= bus.s_tdata[7:4];
          last_q   <= bus.s_tlast;
          byte_cnt <= (byte_cnt == SAT_BYTES) ? byte_cnt : byte_cnt + 11'd1;
        end else begin
          state   <= S_IFG;
          ifg_cnt <= '0;
          txctl_q <= 1'b0;
          txd_q   <= '0;
          err_q   <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.s_tvalid) begin
              state    <= S_PREAMBLE;
              sh       <= bus.dst_mac;
              type_q   <= bus.ethertype;
              nib_cnt  <= '0;
              byte_cnt <= '0;
              crc      <= 32'hFFFFFFFF;
              txctl_q  <= 1'b1;
              txd_q    <= 4'h5;
            end
          end
          S_PREAMBLE: begin
            if (nib_cnt == 4'd14) begin
              state <= S_SFD;
              txd_q <= 4'hD;
            end else begin
              nib_cnt <= nib_cnt + 4'd1;
              txd_q   <= 4'h5;
            end
          end
          S_SFD: begin
            state   <= S_DEST;
            nib_cnt <= '0;
            txd_q   <= sh[3:0];
            sh      <= {4'd0, sh[47:4]};
            crc     <= 32'hFFFFFFFF;
          end
          S_DEST: begin
            crc <= crc_next;
            if (nib_cnt == 4'd11) begin
              state   <= S_SOURCE;
              nib_cnt <= '0;
              txd_q   <= MAC_ADDR[3:0];
              sh      <= {4'd0, MAC_ADDR[47:4]};
            end else begin
              nib_cnt <= nib_cnt + 4'd1;
              txd_q   <= sh[3:0];
              sh      <= {4'd0, sh[47:4]};
            end
          end
          S_SOURCE: begin
            crc <= crc_next;
            if (nib_cnt == 4'd11) begin
              state   <= S_TYPE;
              nib_cnt <= '0;
              txd_q   <= type_q[3:0];
              sh      <= {36'd0, type_q[15:4]};
            end else begin
              nib_cnt <= nib_cnt + 4'd1;
              txd_q   <= sh[3:0];
              sh      <= {4'd0, sh[47:4]};
            end
          end
          S_TYPE: begin
            crc      <= crc_next;
            nib_cnt  <= nib_cnt + 4'd1;
            txd_q    <= sh[3:0];
            sh       <= {4'd0, sh[47:4]};
            tready_q <= (nib_cnt == 4'd2);
          end
          S_PAYLOAD: begin
            crc <= crc_next;
            if (nib_cnt == 4'd0) begin
              nib_cnt  <= 4'd1;
              txd_q    <= hi_nib;
              tready_q <= !last_q && (byte_cnt != MAX_BYTES);
            end else if (last_q) begin
`ifdef RGMII_XMIT_PAD_EN
              if (byte_cnt < 11'(MIN_PAYLOAD)) begin
                state    <= S_PAD;
                nib_cnt  <= '0;
                txd_q    <= '0;
                byte_cnt <= byte_cnt + 11'd1;
              end else
`endif
              begin
                state   <= S_FCS;
                nib_cnt <= '0;
                txd_q   <= fcs[3:0];
                sh      <= {20'd0, fcs[31:4]};
              end
            end else begin
              // 1500 bytes sent and still no s_tlast: oversize abort.
              state   <= S_IFG;
              ifg_cnt <= '0;
              txctl_q <= 1'b0;
              txd_q   <= '0;
              err_q   <= 1'b1;
            end
          end
`ifdef RGMII_XMIT_PAD_EN
          S_PAD: begin
            crc <= crc_next;
            if (nib_cnt == 4'd0) begin
              nib_cnt <= 4'd1;
              txd_q   <= '0;
            end else if (byte_cnt == 11'(MIN_PAYLOAD)) begin
              state   <= S_FCS;
              nib_cnt <= '0;
              txd_q   <= fcs[3:0];
              sh      <= {20'd0, fcs[31:4]};
            end else begin
              nib_cnt  <= '0;
              txd_q    <= '0;
              byte_cnt <= byte_cnt + 11'd1;
            end
          end
`endif
          S_FCS: begin
            if (nib_cnt == 4'd7) begin
              state   <= S_IFG;
              ifg_cnt <= '0;
              txctl_q <= 1'b0;
              txd_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              nib_cnt <= nib_cnt + 4'd1;
              txd_q   <= sh[3:0];
              sh      <= {4'd0, sh[47:4]};
            end
          end
          S_IFG: begin
            if (ifg_cnt == IFG_W'(IFG_CYC - 1)) state <= S_IDLE;
            else                                ifg_cnt <= ifg_cnt + 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            txctl_q <= 1'b0;
            txd_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.mii_txd    = txd_q;
  assign bus.mii_txctl  = txctl_q;
  assign bus.s_tready   = tready_q;
  assign bus.frame_done = done_q;
  assign bus.tx_err     = err_q;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_rgmii_xmit.sv
// Directed bench for rgmii_xmit: wire capture, frame rebuild, CRC residue and cycle-exact timing.
module tb_rgmii_xmit;
  localparam logic [47:0] MAC = 48'h02_11_22_33_44_55;
  localparam int          IFG = 12;
`ifdef RGMII_XMIT_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  rgmii_xmit_if bus ();

  rgmii_xmit #(.MAC_ADDR(MAC), .IFG_BYTES(IFG), .MIN_PAYLOAD(46)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycnt = 0;
  logic [3:0] cap  [0:4095];
  logic [3:0] expn [0:4095];
  int cap_n = 0, exp_n = 0;
  int t_start, t_rise, t_rise2, t_fall1, t_done, t_err, t_idle, t_rdy;
  int n_rise, n_done, n_err, txd_bad = 0;
  bit prev_ctl = 1'b0, prev_busy = 1'b0, acc = 1'b0, feed_en = 1'b0;
  int f_len, f_base, f_drop, idx = 0;
  bit f_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample this cycle's outputs at negedge, then drive inputs for this cycle's closing edge.
  task automatic cyc();
    @(negedge clk);
    cycnt++;
    if (bus.mii_txctl && !prev_ctl) begin
      cap_n = 0;
      n_rise++;
      if (n_rise == 1) t_rise = cycnt;
      else if (n_rise == 2) t_rise2 = cycnt;
    end
    if (!bus.mii_txctl && prev_ctl && t_fall1 < 0) t_fall1 = cycnt;
    if (bus.mii_txctl) begin
      if (cap_n < 4096) cap[cap_n] = bus.mii_txd;
      cap_n++;
    end else if (bus.mii_txd !== 4'h0) txd_bad++;
    if (bus.frame_done) begin n_done++; if (t_done < 0) t_done = cycnt; end
    if (bus.tx_err) begin n_err++; if (t_err < 0) t_err = cycnt; end
    if (bus.s_tready && t_rdy < 0) t_rdy = cycnt;
    if (!bus.busy && prev_busy && t_idle < 0) t_idle = cycnt;
    prev_ctl  = bus.mii_txctl;
    prev_busy = bus.busy;
    if (!bus.busy) idx = 0;
    else if (acc) idx++;
    bus.s_tvalid = feed_en && (idx < f_len) && (idx < f_drop);
    bus.s_tdata  = 8'(f_base + idx);
    bus.s_tlast  = f_last && (idx == f_len - 1);
    if (!bus.busy && bus.s_tvalid && t_start < 0) t_start = cycnt;
    acc = bus.s_tvalid && bus.s_tready;
  endtask

  task automatic clear_marks();
    t_start = -1; t_rise = -1; t_rise2 = -1; t_fall1 = -1; t_done = -1;
    t_err = -1; t_idle = -1; t_rdy = -1; n_rise = 0; n_done = 0; n_err = 0;
  endtask

  task automatic run(input int len_i, input int base_i, input bit last_i, input int drop_i,
                     input int frames, input int budget);
    f_len = len_i; f_base = base_i; f_last = last_i; f_drop = drop_i;
    clear_marks();
    feed_en = 1'b1;
    for (int k = 0; k < budget && (n_done + n_err) < frames; k++) cyc();
    feed_en = 1'b0;
    for (int k = 0; k < 100 && bus.busy; k++) cyc();
    chk("frame_end_in_budget", ((n_done + n_err) >= frames) && !bus.busy, 1);
  endtask

  task automatic build_exp(input logic [47:0] da, input logic [15:0] ty, input int nbytes,
                           input int base_i, input int padto);
    logic [47:0] sa;
    logic [7:0]  b;
    sa = MAC;
    exp_n = 0;
    for (int k = 0; k < 15; k++) expn[exp_n++] = 4'h5;
    expn[exp_n++] = 4'hD;
    for (int k = 0; k < 12; k++) expn[exp_n++] = da[4*k +: 4];
    for (int k = 0; k < 12; k++) expn[exp_n++] = sa[4*k +: 4];
    for (int k = 0; k < 4; k++)  expn[exp_n++] = ty[4*k +: 4];
    for (int k = 0; k < nbytes; k++) begin
      b = 8'(base_i + k);
      expn[exp_n++] = b[3:0];
      expn[exp_n++] = b[7:4];
    end
    for (int k = nbytes; k < padto; k++) begin
      expn[exp_n++] = 4'h0;
      expn[exp_n++] = 4'h0;
    end
  endtask

  function automatic logic [31:0] residue();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 16; k + 1 < cap_n; k += 2) begin
      c = c ^ {24'd0, cap[k+1], cap[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic check_frame(input string tag, input bit complete);
    int mism;
    mism = 0;
    for (int k = 0; k < exp_n && k < cap_n; k++) if (cap[k] !== expn[k]) mism++;
    chk({tag, "_nibbles"}, cap_n, complete ? exp_n + 8 : exp_n);
    chk({tag, "_content"}, mism, 0);
    if (complete) chk({tag, "_crc_residue"}, residue(), 32'hDEBB20E3);
  endtask

  initial begin
    bus.dst_mac = MAC; bus.ethertype = 16'h0800;
    bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
    f_len = 0; f_base = 0; f_last = 1'b0; f_drop = 0;
    clear_marks();
    repeat (3) cyc();
    chk("reset_outputs", {bus.mii_txctl, bus.mii_txd, bus.busy, bus.s_tready, bus.frame_done, bus.tx_err}, 0);
    rst = 1'b0;
    repeat (2) cyc();

    // 46-byte frame to our own address, IPv4 type.
    bus.dst_mac = MAC; bus.ethertype = 16'h0800;
    run(46, 0, 1'b1, 100000, 1, 400);
    chk("t1_first_nibble_cycle", t_rise - t_start, 1);
    chk("t1_first_tready_cycle", t_rdy - t_start, 44);
    chk("t1_txctl_fall_cycle", t_fall1 - t_start, 145);
    chk("t1_frame_done_cycle", t_done - t_start, 145);
    chk("t1_busy_low_cycle", t_idle - t_start, 169);
    chk("t1_no_err", n_err, 0);
    build_exp(MAC, 16'h0800, 46, 0, 46);
    check_frame("t1", 1'b1);

    // 1-byte ARP frame: padded to 46 bytes only when padding is built in.
    bus.dst_mac = 48'hFFFF_FFFF_FFFF; bus.ethertype = 16'h0806;
    run(1, 8'hAB, 1'b1, 100000, 1, 400);
    build_exp(48'hFFFF_FFFF_FFFF, 16'h0806, 1, 8'hAB, PAD ? 46 : 1);
    check_frame("t2", 1'b1);
    chk("t2_total_nibbles", cap_n, PAD ? 144 : 54);

    // Underrun: byte index 10 never offered.
    bus.dst_mac = 48'h0A0B_0C0D_0E0F; bus.ethertype = 16'h0800;
    run(46, 8'h10, 1'b1, 10, 1, 400);
    chk("t3_tx_err_cycle", t_err - t_start, 65);
    chk("t3_txctl_fall_cycle", t_fall1 - t_start, 65);
    chk("t3_ifg_len", t_idle - t_err, 2 * IFG);
    chk("t3_no_done", n_done, 0);
    build_exp(48'h0A0B_0C0D_0E0F, 16'h0800, 10, 8'h10, 10);
    check_frame("t3", 1'b0);

    // Oversize: never any s_tlast; abort when byte 1501 would be requested.
    run(1600, 0, 1'b0, 100000, 1, 4000);
    chk("t4_tx_err_cycle", t_err - t_start, 3045);
    chk("t4_no_done", n_done, 0);
    build_exp(48'h0A0B_0C0D_0E0F, 16'h0800, 1500, 0, 1500);
    check_frame("t4", 1'b0);

    // Maximum legal payload: 16 + 28 + 2*1500 + 8 nibbles.
    run(1500, 7, 1'b1, 100000, 1, 4000);
    chk("t4b_no_err", n_err, 0);
    build_exp(48'h0A0B_0C0D_0E0F, 16'h0800, 1500, 7, 1500);
    check_frame("t4b", 1'b1);

    // Back-to-back with s_tvalid ready again at IDLE: 24 IFG cycles plus the start cycle.
    run(46, 8'h40, 1'b1, 100000, 2, 600);
    chk("t5_frames_done", n_done, 2);
    chk("t5_gap_fall_to_rise", t_rise2 - t_fall1, 2 * IFG + 1);
    build_exp(48'h0A0B_0C0D_0E0F, 16'h0800, 46, 8'h40, 46);
    check_frame("t5_second", 1'b1);

    // Reset in cycle 30 of a frame; the next frame starts right after.
    f_len = 46; f_base = 8'h20; f_last = 1'b1; f_drop = 100000;
    clear_marks();
    feed_en = 1'b1;
    for (int k = 0; k < 200 && !(t_start >= 0 && cycnt - t_start == 30); k++) cyc();
    chk("t6_reached_cycle30", cycnt - t_start, 30);
    rst = 1'b1;
    cyc();
    chk("t6_outputs_after_reset",
        {bus.mii_txctl, bus.mii_txd, bus.busy, bus.s_tready, bus.frame_done, bus.tx_err}, 0);
    rst = 1'b0;
    t_start = cycnt; n_done = 0; n_err = 0; t_done = -1;
    for (int k = 0; k < 400 && n_done == 0; k++) cyc();
    feed_en = 1'b0;
    for (int k = 0; k < 100 && bus.busy; k++) cyc();
    chk("t6_done_cycle", t_done - t_start, 145);
    chk("t6_no_err", n_err, 0);
    build_exp(48'h0A0B_0C0D_0E0F, 16'h0800, 46, 8'h20, 46);
    check_frame("t6", 1'b1);

    chk("txd_zero_when_idle", txd_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
